// File: rtl/motor_cmd_scheduler.sv
// motor_cmd_scheduler: arbitrates drive/stop requests and streams 28-byte JSON motor frames to uart_tx, with keepalive resend
module motor_cmd_scheduler #(
    parameter int KEEPALIVE_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       drive_req,
    input  logic [7:0] left_speed,
    input  logic [7:0] right_speed,
    input  logic       stop_req,
    output logic [7:0] data_tx,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_done
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
    localparam int CW = KEEPALIVE_CYCLES > 1 ? $clog2(KEEPALIVE_CYCLES) : 1;
    localparam logic [87:0] HEAD = "{\"T\":1,\"L\":";
    localparam logic [39:0] MID = ",\"R\":";
    state_t state;
    logic drive_pend, stop_pend, last_ok, ka_exp, stop_now, drive_now;
    logic [7:0] pend_l, pend_r, cur_l, cur_r, nxt_byte;
    logic [39:0] l_f, r_f;
    logic [4:0] idx;
    logic [CW-1:0] ka_cnt;
    logic [223:0] frame, shifted;
    function automatic logic [39:0] fmt(input logic [7:0] s);
        logic signed [7:0] c;
        logic [6:0] m;
        c = $signed(s) > 8'sd100 ? 8'sd100 : ($signed(s) < -8'sd100 ? -8'sd100 : $signed(s));
        m = c[7] ? 7'(-c) : 7'(c);
        return {c[7] ? 8'h2d : 8'h20,
                m == 7'd100 ? 32'h312e3030 : {8'h30, 8'h2e, 8'h30 + 8'(m / 7'd10), 8'h30 + 8'(m % 7'd10)}};
    endfunction
    assign stop_now = stop_req | stop_pend;
    assign drive_now = drive_req | drive_pend;
    assign ka_exp = (KEEPALIVE_CYCLES != 0) && (ka_cnt == CW'(KEEPALIVE_CYCLES - 1));
    assign frame = {HEAD, l_f, MID, r_f, 8'h7d, 8'h0a};
    assign shifted = frame << (8 * (32'(idx) + 1));
    assign nxt_byte = shifted[223:216];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            valid <= 1'b0;
            busy <= 1'b0;
            frame_done <= 1'b0;
            data_tx <= 8'h00;
            drive_pend <= 1'b0;
            stop_pend <= 1'b0;
            last_ok <= 1'b0;
            ka_cnt <= '0;
            idx <= '0;
        end else begin
            frame_done <= 1'b0;
            if (stop_req) stop_pend <= 1'b1;
            if (drive_req && !stop_req) begin
                drive_pend <= 1'b1;
                pend_l <= left_speed;
                pend_r <= right_speed;
            end
            case (state)
                IDLE: begin
                    if (stop_now) begin
                        cur_l <= 8'd0;
                        cur_r <= 8'd0;
                        stop_pend <= 1'b0;
                        drive_pend <= 1'b0;
                        busy <= 1'b1;
                        ka_cnt <= '0;
                        state <= LOAD;
                    end else if (drive_now) begin
                        cur_l <= drive_req ? left_speed : pend_l;
                        cur_r <= drive_req ? right_speed : pend_r;
                        drive_pend <= 1'b0;
                        busy <= 1'b1;
                        ka_cnt <= '0;
                        state <= LOAD;
                    end else if (ka_exp && last_ok) begin
                        busy <= 1'b1;
                        ka_cnt <= '0;
                        state <= LOAD;
                    end else if (!ka_exp) begin
                        ka_cnt <= ka_cnt + CW'(1);
                    end
                end
                LOAD: begin
                    l_f <= fmt(cur_l);
                    r_f <= fmt(cur_r);
                    idx <= '0;
                    last_ok <= 1'b1;
                    valid <= 1'b1;
                    data_tx <= 8'h7b;
                    state <= SEND;
                end
                SEND: begin
                    if (ready) begin
                        if (idx == 5'd27) begin
                            valid <= 1'b0;
                            busy <= 1'b0;
                            frame_done <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 5'd1;
                            data_tx <= nxt_byte;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// tb_motor_cmd_scheduler: vector table plus byte scoreboard for motor_cmd_scheduler frames, arbitration, keepalive and reset
module tb_motor_cmd_scheduler;
    logic clk = 0, rst = 1, drive_req = 0, stop_req = 0, ready = 1;
    logic [7:0] left_speed = 0, right_speed = 0, data_tx;
    logic valid, busy, frame_done;
    int errors = 0, checks = 0, valid_cycles = 0;
    bit ready_rand = 0;
    byte unsigned q[$];
    typedef struct {
        logic [7:0] l;
        logic [7:0] r;
        bit stop;
        string el;
        string er;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    motor_cmd_scheduler #(.KEEPALIVE_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .drive_req(drive_req), .left_speed(left_speed),
        .right_speed(right_speed), .stop_req(stop_req), .data_tx(data_tx),
        .valid(valid), .ready(ready), .busy(busy), .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_frame(input string el, input string er);
        string s;
        s = {"{\"T\":1,\"L\":", el, ",\"R\":", er, "}\n"};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask

    task automatic request(input logic [7:0] l, input logic [7:0] r, input bit d, input bit s);
        @(posedge clk); #1;
        left_speed = l; right_speed = r; drive_req = d; stop_req = s;
        @(posedge clk); #1;
        drive_req = 0; stop_req = 0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < budget);
        if (!frame_done) check("frame_done_timeout", 0, 1);
    endtask

    task automatic monitor();
        logic hold = 0;
        logic [7:0] held = 0;
        forever begin
            @(negedge clk);
            if (rst) hold = 0;
            else begin
                if (hold) begin
                    check("hold_valid", valid, 1);
                    check("hold_data", data_tx, held);
                end
                if (valid) valid_cycles++;
                if (valid && ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got 0x%0h expected no byte", data_tx);
                    end else check("byte", data_tx, q.pop_front());
                end
                hold = valid && !ready;
                held = data_tx;
            end
        end
    endtask

    task automatic drive_ready();
        forever begin
            @(posedge clk); #1;
            ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, v0;
        vecs[0] = '{8'd50, 8'(-37), 1'b0, " 0.50", "-0.37"};
        vecs[1] = '{8'd127, 8'(-128), 1'b0, " 1.00", "-1.00"};
        vecs[2] = '{8'd0, 8'd100, 1'b0, " 0.00", " 1.00"};
        vecs[3] = '{8'(-100), 8'd101, 1'b0, "-1.00", " 1.00"};
        vecs[4] = '{8'(-101), 8'd9, 1'b0, "-1.00", " 0.09"};
        vecs[5] = '{8'd20, 8'd0, 1'b1, " 0.00", " 0.00"};
        vecs[6] = '{8'(-1), 8'd99, 1'b0, "-0.01", " 0.99"};
        fork
            monitor();
            drive_ready();
        join_none
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data", data_tx, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        @(posedge clk); #1 rst = 0;

        for (int i = 0; i < 7; i++) begin
            push_frame(vecs[i].el, vecs[i].er);
            request(vecs[i].l, vecs[i].r, 1, vecs[i].stop);
            @(negedge clk);
            check("load_busy", busy, 1);
            check("load_valid", valid, 0);
            @(negedge clk);
            check("first_valid", valid, 1);
            check("first_byte", data_tx, 8'h7b);
            wait_done(60, n);
            check("frame_cycles", n, 28);
            check("done_busy", busy, 0);
            check("done_valid", valid, 0);
            check("queue_empty", q.size(), 0);
            @(negedge clk);
            check("done_pulse", frame_done, 0);
            repeat (5) @(negedge clk);
            check("no_extra", valid, 0);
        end

        ready_rand = 1;
        push_frame("-0.55", " 0.07");
        request(8'(-55), 8'd7, 1, 0);
        wait_done(400, n);
        check("rand_done_valid", valid, 0);
        check("rand_queue_empty", q.size(), 0);
        ready_rand = 0;
        repeat (3) @(negedge clk);

        push_frame(" 0.10", " 0.00");
        push_frame(" 0.00", " 0.00");
        request(8'd10, 8'd0, 1, 0);
        repeat (5) @(negedge clk);
        request(8'd30, 8'd0, 1, 0);
        request(8'd0, 8'd0, 0, 1);
        wait_done(60, n);
        check("mid_queue_left", q.size(), 28);
        @(negedge clk);
        check("gap_valid", valid, 0);
        @(negedge clk);
        check("gap_next_valid", valid, 1);
        check("gap_next_byte", data_tx, 8'h7b);
        wait_done(60, n);
        check("mid_queue_empty", q.size(), 0);
        repeat (20) @(negedge clk);
        check("no_l30_frame", valid, 0);

        push_frame(" 0.25", " 0.25");
        request(8'd25, 8'd25, 1, 0);
        wait_done(60, n);
        for (int k = 0; k < 2; k++) begin
            push_frame(" 0.25", " 0.25");
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!valid && n < 300);
            check("keepalive_delay", n, 101);
            wait_done(60, n);
            check("keepalive_frame_len", n, 28);
            check("keepalive_queue_empty", q.size(), 0);
        end
        #2 rst = 1;
        @(posedge clk); @(posedge clk); #1 rst = 0;
        v0 = valid_cycles;
        repeat (300) @(negedge clk);
        check("no_keepalive_after_rst", valid_cycles - v0, 0);

        push_frame(" 0.40", "-0.40");
        request(8'd40, 8'(-40), 1, 0);
        repeat (14) @(negedge clk);
        check("byte12_valid", valid, 1);
        check("byte12_data", data_tx, 8'h30);
        #2 rst = 1;
        @(negedge clk);
        check("midrst_valid", valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", frame_done, 0);
        q.delete();
        #2 rst = 0;
        v0 = valid_cycles;
        repeat (250) @(negedge clk);
        check("silent_after_midrst", valid_cycles - v0, 0);
        push_frame(" 0.01", " 0.00");
        request(8'd1, 8'd0, 1, 0);
        wait_done(60, n);
        check("post_rst_queue_empty", q.size(), 0);
        check("post_rst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
